// File: rtl/io_trace_pkg.sv
// Shared types for the I/O write-bus trace buffer.
// Capture state encoding and trace-mode constants.
package io_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HALTED
  } state_t;

  localparam logic MODE_HALT = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: one write port, one async read port.
// Contents are not reset; validity is tracked by the controller.
module trace_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one entry per write strobe.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/io_trace_buffer.sv
// Captures CPU I/O writes with timestamp and sequence number.
// Halt or wrap on full; head entry is shown ahead on rd_*.
module io_trace_buffer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int SEQ_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        io_data,
  input  logic [ADDR_W-1:0]        io_addr,
  input  logic                     io_we,
  input  logic [2**ADDR_W-1:0]     port_en,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     wrap_mode,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [TS_W-1:0]          rd_ts,
  output logic [SEQ_W-1:0]         rd_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     capturing
);

  import io_trace_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + ADDR_W + TS_W + SEQ_W;

  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [TS_W-1:0]  TS_ONE   = TS_W'(1);
  localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [TS_W-1:0]  ts;
  logic [SEQ_W-1:0] seq;
  logic             wrap_q;

  logic          in_cap;
  logic          evt;
  logic          do_pop;
  logic          is_full;
  logic          mem_we;
  logic          overwrite;
  logic          drop;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  assign in_cap  = (state == ST_CAPTURE);
  assign evt     = in_cap & io_we & port_en[io_addr];
  assign is_full = (count == CNT_FULL);
  assign do_pop  = rd_valid & rd_ready;

  // A full buffer only refuses the event if nothing leaves
  // this cycle; wrap mode then recycles the head slot.
  assign overwrite = evt & is_full & !do_pop
                   & (wrap_q == MODE_WRAP);
  assign drop      = evt & is_full & !do_pop
                   & (wrap_q == MODE_HALT);
  assign mem_we    = evt & !start & !drop;

  assign wdata = {io_data, io_addr, ts, seq};

  trace_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign {rd_data, rd_addr, rd_ts, rd_seq} = rdata;

  assign empty     = (count == '0);
  assign full      = is_full;
  assign rd_valid  = !empty;
  assign capturing = in_cap;

  // Capture FSM, pointers, counters and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      wrap_q   <= MODE_HALT;
    end else if (start) begin
      state    <= ST_CAPTURE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      wrap_q   <= wrap_mode;
    end else begin
      if (in_cap) ts <= ts + TS_ONE;
      if (evt) seq <= seq + SEQ_ONE;
      if (mem_we) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop | overwrite) rd_ptr <= rd_ptr + PTR_ONE;
      if (mem_we & !do_pop & !overwrite)
        count <= count + CNT_ONE;
      else if (do_pop & !mem_we)
        count <= count - CNT_ONE;
      if (overwrite | drop) overflow <= 1'b1;
      if (in_cap) begin
        if (stop)      state <= ST_IDLE;
        else if (drop) state <= ST_HALTED;
      end
    end
  end

endmodule

// File: tb/tb_io_trace_buffer.sv
// Scoreboard bench for io_trace_buffer with directed vectors.
// Expected entries are queued by stimulus, checked on each pop.
module tb_io_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  io_data = '0;
  logic [3:0]  io_addr = '0;
  logic        io_we = 1'b0;
  logic [15:0] port_en = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        wrap_mode = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [3:0]  rd_addr;
  logic [15:0] rd_ts;
  logic [7:0]  rd_seq;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        capturing;

  typedef struct {
    logic [7:0]  d;
    logic [3:0]  a;
    logic [15:0] ts;
    logic [7:0]  seq;
  } ent_t;

  ent_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  io_trace_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .io_data   (io_data),
    .io_addr   (io_addr),
    .io_we     (io_we),
    .port_en   (port_en),
    .start     (start),
    .stop      (stop),
    .wrap_mode (wrap_mode),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .rd_ts     (rd_ts),
    .rd_seq    (rd_seq),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .capturing (capturing)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted pop must match the queued head.
  always @(negedge clk) begin
    if (rd_valid && rd_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got seq %0d, none queued",
                 rd_seq);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        if ({rd_data, rd_addr, rd_ts, rd_seq} !==
            {e.d, e.a, e.ts, e.seq}) begin
          n_bad++;
          $display("FAIL entry: got d=%0d a=%0d ts=%0d seq=%0d %s",
                   rd_data, rd_addr, rd_ts, rd_seq,
                   $sformatf("want d=%0d a=%0d ts=%0d seq=%0d",
                             e.d, e.a, e.ts, e.seq));
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int a, input int t,
                      input int s);
    ent_t e;
    e.d = d[7:0];
    e.a = a[3:0];
    e.ts = t[15:0];
    e.seq = s[7:0];
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic wm, input logic [15:0] en);
    port_en = en;
    wrap_mode = wm;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    io_we = 1'b1;
    io_addr = a[3:0];
    io_data = d[7:0];
    tick();
    io_we = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic drain(input string nm);
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && rd_valid; i++) tick();
    rd_ready = 1'b0;
    chk({nm, "_valid"}, 32'(rd_valid), 0);
    chk({nm, "_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_cap", 32'(capturing), 0);
    reset = 1'b1;
    tick();

    // Basic capture: five writes to port 0.
    do_start(1'b0, 16'h0001);
    chk("t1_cap", 32'(capturing), 1);
    begin
      int v[5] = '{0, 1, 1, 2, 3};
      for (int i = 0; i < 5; i++) begin
        push(v[i], 0, i, i);
        wr(0, v[i]);
      end
    end
    chk("t1_count", 32'(count), 5);
    do_stop();
    chk("t1_idle", 32'(capturing), 0);
    drain("t1");

    // Port filter: only port 2 is enabled.
    do_start(1'b0, 16'h0004);
    wr(1, 8'h11);
    push(8'h22, 2, 1, 0);
    wr(2, 8'h22);
    wr(3, 8'h33);
    chk("t2_count", 32'(count), 1);
    chk("t2_addr", 32'(rd_addr), 2);
    do_stop();
    drain("t2");

    // Event in the stop cycle is still captured.
    do_start(1'b0, 16'h0001);
    push(8'hAA, 0, 0, 0);
    stop = 1'b1;
    wr(0, 8'hAA);
    stop = 1'b0;
    chk("t3_cap", 32'(capturing), 0);
    chk("t3_count", 32'(count), 1);
    drain("t3");

    // Start and stop together: start wins.
    port_en = 16'h0001;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("t4_cap", 32'(capturing), 1);
    do_stop();

    // Halt mode: 17th write dropped, FSM halts.
    do_start(1'b0, 16'h0001);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) push(i, 0, i, i);
      wr(0, i);
    end
    chk("t5_count", 32'(count), 16);
    chk("t5_full", 32'(full), 1);
    chk("t5_ovf", 32'(overflow), 1);
    chk("t5_cap", 32'(capturing), 0);
    drain("t5");
    chk("t5_ovf_sticky", 32'(overflow), 1);

    // Wrap mode: 20 writes keep the newest 16.
    do_start(1'b1, 16'h0001);
    chk("t6_ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 20; i++) begin
      if (i >= 4) push(i, 0, i, i);
      wr(0, i);
    end
    chk("t6_count", 32'(count), 16);
    chk("t6_ovf", 32'(overflow), 1);
    chk("t6_cap", 32'(capturing), 1);
    chk("t6_head", 32'(rd_seq), 4);
    do_stop();
    drain("t6");

    // Full buffer, event plus pop in the same cycle.
    do_start(1'b0, 16'h0001);
    for (int i = 0; i < 16; i++) begin
      push(i, 0, i, i);
      wr(0, i);
    end
    chk("t7_full", 32'(full), 1);
    push(16, 0, 16, 16);
    rd_ready = 1'b1;
    wr(0, 16);
    rd_ready = 1'b0;
    chk("t7_count", 32'(count), 16);
    chk("t7_ovf", 32'(overflow), 0);
    chk("t7_cap", 32'(capturing), 1);
    chk("t7_head", 32'(rd_seq), 1);
    do_stop();
    drain("t7");

    // Reset mid-capture discards everything.
    do_start(1'b0, 16'h0001);
    for (int i = 0; i < 3; i++) wr(0, i + 8'h40);
    chk("t8_pre", 32'(count), 3);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    chk("t8_empty", 32'(empty), 1);
    chk("t8_valid", 32'(rd_valid), 0);
    chk("t8_cap", 32'(capturing), 0);
    chk("t8_count", 32'(count), 0);
    do_start(1'b0, 16'h0001);
    push(8'h55, 0, 0, 0);
    wr(0, 8'h55);
    chk("t8_seq", 32'(rd_seq), 0);
    do_stop();
    drain("t8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_trace_buffer.md
IO_TRACE_BUFFER -- requirements
Module: io_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, I/O data width.
REQ-002 SHALL have parameter ADDR_W, default 4, I/O port address width.
REQ-003 SHALL have parameter DEPTH, default 16, entry count, power of two, minimum 2.
REQ-004 SHALL have parameter TS_W, default 16, timestamp width; parameter SEQ_W, default 8, sequence-number width.
REQ-005 SHALL have port clk  in  1  sole clock, all flops on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports io_data  in  DATA_W, io_addr  in  ADDR_W, io_we  in  1: the CPU I/O write bus, sampled each edge.
REQ-008 SHALL have port port_en  in  2**ADDR_W  per-port capture enable, bit i enables io_addr==i.
REQ-009 SHALL have ports start  in  1 and stop  in  1: single-cycle capture controls.
REQ-010 SHALL have port wrap_mode  in  1  0 = halt when full, 1 = overwrite oldest entry; sampled only on start.
REQ-011 SHALL have port rd_ready  in  1  pop head entry when rd_valid.
REQ-012 SHALL have ports rd_valid  out  1, rd_data  out  DATA_W, rd_addr  out  ADDR_W, rd_ts  out  TS_W, rd_seq  out  SEQ_W: show-ahead head entry.
REQ-013 SHALL have ports count  out  clog2(DEPTH)+1, full  out  1, empty  out  1, overflow  out  1 (sticky), capturing  out  1.

Function
REQ-014 States: IDLE, CAPTURE, HALTED; capturing = (state==CAPTURE).
REQ-015 IDLE/HALTED + start -> CAPTURE: flush buffer, clear timestamp, sequence and overflow, latch wrap_mode, all in that cycle.
REQ-016 CAPTURE + stop -> IDLE; an event in the stop cycle is captured; start and stop together: start wins.
REQ-017 Event = io_we & port_en[io_addr] in CAPTURE; each event stores {io_data, io_addr, ts, seq} and then increments seq, modulo 2**SEQ_W.
REQ-018 Timestamp counter increments every cycle in CAPTURE, modulo 2**TS_W, holds otherwise; first post-start cycle has ts 0.
REQ-019 Write-to-read latency: entry visible on rd_* and rd_valid high the cycle after the event edge.
REQ-020 Pop occurs when rd_valid & rd_ready; head advances next edge; pop when empty is ignored.
REQ-021 Halt mode, event while full (no pop same cycle): entry dropped, overflow set, state -> HALTED; reads still allowed.
REQ-022 Wrap mode, event while full: oldest entry overwritten, head advances, count stays DEPTH, overflow set, no state change.
REQ-023 Simultaneous event and pop: both performed, count unchanged; when full, no drop and no overwrite occurs.
REQ-024 Pointers wrap modulo DEPTH; full = (count==DEPTH), empty = (count==0), rd_valid = !empty.
REQ-025 Sequence numbers increment also for dropped/overwritten events, so gaps in rd_seq expose loss.
REQ-026 Reads in IDLE and HALTED drain the buffer normally.

Reset
REQ-027 Reset asserted: state IDLE, pointers/count/ts/seq 0, overflow 0, rd_valid 0, empty 1, full 0, capturing 0, latched mode 0.
REQ-028 Reset mid-capture aborts immediately; buffer contents are discarded, storage array need not be cleared.

Structure
REQ-029 Package io_trace_pkg SHALL hold the state enum and the WRAP/HALT mode constants.
REQ-030 Storage SHALL be a sub-module trace_fifo_mem (1 write, 1 async read port, DEPTH x (DATA_W+ADDR_W+TS_W+SEQ_W)); control stays in io_trace_buffer.

Verification
REQ-031 start, wrap_mode=0, port_en=0x0001, 5 writes to port 0 of 0,1,1,2,3 on consecutive cycles -> 5 entries, rd_seq 0..4, rd_ts 0..4 (first write in first post-start cycle), rd_data 0,1,1,2,3.
REQ-032 port_en=0x0004, writes to ports 1,2,3 -> only port 2 entry stored, rd_addr=2, count=1.
REQ-033 Halt mode, DEPTH=16, 17 writes with rd_ready=0 -> count=16, overflow=1, state HALTED, entries seq 0..15.
REQ-034 Wrap mode, DEPTH=16, 20 writes with rd_ready=0 -> count=16, overflow=1, head rd_seq=4, last entry seq 19, still CAPTURE.
REQ-035 Full buffer, event with rd_ready=1 same cycle -> count stays 16, overflow stays 0, head seq advances by 1.
REQ-036 Reset pulse after 3 captured events -> next cycle empty=1, rd_valid=0, capturing=0, count=0; start then restarts seq at 0.
